pipe_hazard_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage scalar/vector pipeline.
- Drives enable and flush inputs of the PC and the four pipeline registers: fdpipe, depipe, empipe and mwpipe.
- Resolves three hazard sources: load-use data hazards, multi-cycle data-memory accesses and taken branches.
- Keeps a stall-cycle performance counter.

---
 rtl/pipe_hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: load-use stalls,
// multi-cycle data-memory freezes, taken-branch squashes and a stall counter.
module pipe_hazard_ctrl #(
  parameter int REG_AW  = 4,
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] regSrcA_D,
  input  logic [REG_AW-1:0] regSrcB_D,
  input  logic              useA_D,
  input  logic              useB_D,
  input  logic [REG_AW-1:0] regDst_E,
  input  logic              regw_E,
  input  logic              regmem_E,
  input  logic              memreq_M,
  input  logic              branch_E,
  output logic              en_PC,
  output logic              en_FD,
  output logic              en_DE,
  output logic              en_EM,
  output logic              en_MW,
  output logic              flush_FD,
  output logic              flush_DE,
  output logic              flush_MW,
  output logic              busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  typedef struct packed {
    logic en_pc;
    logic en_fd;
    logic en_de;
    logic en_em;
    logic en_mw;
    logic flush_fd;
    logic flush_de;
    logic flush_mw;
  } ctrl_t;

  // Stage-register control patterns, fields ordered as in ctrl_t.
  localparam ctrl_t CTRL_OFF    = 8'b00000_000;
  localparam ctrl_t CTRL_PASS   = 8'b11111_000;
  localparam ctrl_t CTRL_FREEZE = 8'b00001_001;
  localparam ctrl_t CTRL_BRANCH = 8'b11111_110;
  localparam ctrl_t CTRL_LDUSE  = 8'b00111_010;

  // A single-cycle memory never needs a freeze; otherwise the first freeze
  // cycle is spent in RUN, so the wait counter covers the remaining MEM_LAT-2.
  localparam logic       FREEZE_EN = (MEM_LAT > 1);
  localparam logic [3:0] WAIT_LOAD = (MEM_LAT > 1) ? 4'(MEM_LAT - 2) : 4'd0;

  state_t           state_q, state_d;
  logic [3:0]       wait_q, wait_d;
  logic [CNT_W-1:0] stall_q;
  ctrl_t            ctrl;
  logic             busy_c;
  logic             load_use;

  assign load_use = regw_E && regmem_E &&
                    ((useA_D && (regSrcA_D == regDst_E)) ||
                     (useB_D && (regSrcB_D == regDst_E)));

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    ctrl    = CTRL_OFF;
    busy_c  = 1'b0;
    state_d = state_q;
    wait_d  = wait_q;
    // Outputs are held at zero for as long as reset is asserted.
    if (rst) begin
      unique case (state_q)
        RUN: begin
          if (memreq_M && FREEZE_EN) begin
            ctrl    = CTRL_FREEZE;
            state_d = MEM_WAIT;
            wait_d  = WAIT_LOAD;
          end else if (branch_E) begin
            ctrl = CTRL_BRANCH;
          end else if (load_use) begin
            ctrl = CTRL_LDUSE;
          end else begin
            ctrl = CTRL_PASS;
          end
        end
        MEM_WAIT: begin
          busy_c = 1'b1;
          if (wait_q != 4'd0) begin
            ctrl   = CTRL_FREEZE;
            wait_d = wait_q - 4'd1;
          end else begin
            // Release: the M instruction leaves this edge, so memreq_M is not
            // looked at; only the flushes follow the current hazards.
            ctrl    = CTRL_PASS;
            state_d = RUN;
            if (branch_E) begin
              ctrl.flush_fd = 1'b1;
              ctrl.flush_de = 1'b1;
            end else if (load_use) begin
              ctrl.flush_de = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      wait_q  <= 4'd0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (!ctrl.en_pc && (stall_q != {CNT_W{1'b1}}))
        stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign en_PC     = ctrl.en_pc;
  assign en_FD     = ctrl.en_fd;
  assign en_DE     = ctrl.en_de;
  assign en_EM     = ctrl.en_em;
  assign en_MW     = ctrl.en_mw;
  assign flush_FD  = ctrl.flush_fd;
  assign flush_DE  = ctrl.flush_de;
  assign flush_MW  = ctrl.flush_mw;
  assign busy      = busy_c;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: four instances with MEM_LAT = 1, 3, 4, 8
// share one stimulus stream; each section checks the instance it targets.
module tb_pipe_hazard_ctrl;

  localparam int REG_AW = 4;
  localparam int CNT_W  = 16;

  // Expected control vectors {en_PC,en_FD,en_DE,en_EM,en_MW,flush_FD,flush_DE,flush_MW}
  localparam logic [7:0] C_ZERO = 8'b00000_000;
  localparam logic [7:0] C_RUN  = 8'b11111_000;
  localparam logic [7:0] C_FRZ  = 8'b00001_001;
  localparam logic [7:0] C_BR   = 8'b11111_110;
  localparam logic [7:0] C_LU   = 8'b00111_010;
  localparam logic [7:0] C_RLLU = 8'b11111_010;

  logic              clk;
  logic              rst;
  logic [REG_AW-1:0] regSrcA_D, regSrcB_D, regDst_E;
  logic              useA_D, useB_D, regw_E, regmem_E, memreq_M, branch_E;

  logic [3:0] en_pc, en_fd, en_de, en_em, en_mw;
  logic [3:0] fl_fd, fl_de, fl_mw, busy;
  logic [CNT_W-1:0] cnt [4];

  int n_checks = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    pipe_hazard_ctrl #(
      .REG_AW (REG_AW),
      .MEM_LAT((g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 4 : 8),
      .CNT_W  (CNT_W)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .regSrcA_D(regSrcA_D),
      .regSrcB_D(regSrcB_D),
      .useA_D   (useA_D),
      .useB_D   (useB_D),
      .regDst_E (regDst_E),
      .regw_E   (regw_E),
      .regmem_E (regmem_E),
      .memreq_M (memreq_M),
      .branch_E (branch_E),
      .en_PC    (en_pc[g]),
      .en_FD    (en_fd[g]),
      .en_DE    (en_de[g]),
      .en_EM    (en_em[g]),
      .en_MW    (en_mw[g]),
      .flush_FD (fl_fd[g]),
      .flush_DE (fl_de[g]),
      .flush_MW (fl_mw[g]),
      .busy     (busy[g]),
      .stall_cnt(cnt[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ctrl_of(int i);
    return {en_pc[i], en_fd[i], en_de[i], en_em[i], en_mw[i], fl_fd[i], fl_de[i], fl_mw[i]};
  endfunction

  task automatic check(string tag, logic [31:0] observed, logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    regSrcA_D = '0; regSrcB_D = '0; regDst_E = '0;
    useA_D = 0; useB_D = 0; regw_E = 0; regmem_E = 0;
    memreq_M = 0; branch_E = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_in();
    tick();
    rst = 1'b1;
  endtask

  task automatic set_lu(logic [3:0] dst, logic [3:0] sa, logic ua, logic [3:0] sb, logic ub,
                        logic mem);
    regw_E = 1; regmem_E = mem; regDst_E = dst;
    regSrcA_D = sa; useA_D = ua; regSrcB_D = sb; useB_D = ub;
  endtask

  initial begin
    rst = 1'b0;
    clear_in();

    // Reset held three cycles: everything off.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) check($sformatf("rst_ctrl%0d", i), 32'(ctrl_of(i)), 32'(C_ZERO));
      check("rst_busy", 32'(busy), 32'h0);
      tick();
    end
    rst = 1'b1;

    // Idle for 10 cycles.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("idle_ctrl", 32'(ctrl_of(1)), 32'(C_RUN));
      tick();
    end
    @(negedge clk);
    check("idle_cnt", 32'(cnt[1]), 32'h0);
    check("idle_busy", 32'(busy), 32'h0);
    tick();

    // Load-use on source A, then cleared.
    set_lu(4'h3, 4'h3, 1, 4'h0, 0, 1);
    @(negedge clk);
    check("lu_a", 32'(ctrl_of(1)), 32'(C_LU));
    tick();
    clear_in();
    @(negedge clk);
    check("lu_after", 32'(ctrl_of(1)), 32'(C_RUN));
    check("lu_cnt", 32'(cnt[1]), 32'h1);
    tick();
    // Not a load: no stall.
    set_lu(4'h3, 4'h3, 1, 4'h0, 0, 0);
    @(negedge clk);
    check("lu_noload", 32'(ctrl_of(1)), 32'(C_RUN));
    tick();
    // Source B match.
    set_lu(4'h5, 4'h1, 1, 4'h5, 1, 1);
    @(negedge clk);
    check("lu_b", 32'(ctrl_of(1)), 32'(C_LU));
    tick();
    // Register 0 is an ordinary register.
    set_lu(4'h0, 4'h0, 1, 4'h7, 0, 1);
    @(negedge clk);
    check("lu_r0", 32'(ctrl_of(1)), 32'(C_LU));
    tick();
    // Index match but source unused; and used but mismatched.
    set_lu(4'h9, 4'h9, 0, 4'h9, 0, 1);
    @(negedge clk);
    check("lu_unused", 32'(ctrl_of(1)), 32'(C_RUN));
    tick();
    set_lu(4'h4, 4'h3, 1, 4'h2, 1, 1);
    @(negedge clk);
    check("lu_nomatch", 32'(ctrl_of(1)), 32'(C_RUN));
    tick();
    clear_in();
    @(negedge clk);
    check("lu_cnt3", 32'(cnt[1]), 32'h3);
    tick();

    // Memory freeze, MEM_LAT=3 (inst 1) and MEM_LAT=1 (inst 0).
    do_reset();
    memreq_M = 1;
    @(negedge clk);
    check("mem_f1", 32'(ctrl_of(1)), 32'(C_FRZ));
    check("mem_lat1", 32'(ctrl_of(0)), 32'(C_RUN));
    tick();
    @(negedge clk);
    check("mem_f2", 32'(ctrl_of(1)), 32'(C_FRZ));
    check("mem_f2_busy", 32'(busy[1]), 32'h1);
    tick();
    @(negedge clk);
    check("mem_rel", 32'(ctrl_of(1)), 32'(C_RUN));
    tick();
    memreq_M = 0;
    @(negedge clk);
    check("mem_run", 32'(ctrl_of(1)), 32'(C_RUN));
    check("mem_run_busy", 32'(busy[1]), 32'h0);
    check("mem_cnt", 32'(cnt[1]), 32'h2);
    check("mem_lat1_cnt", 32'(cnt[0]), 32'h0);
    tick();

    // Load-use present at the release cycle (MEM_LAT=3): enables all on, DE flushed.
    do_reset();
    memreq_M = 1;
    set_lu(4'h6, 4'h6, 1, 4'h0, 0, 1);
    @(negedge clk);
    check("rlu_f1", 32'(ctrl_of(1)), 32'(C_FRZ));
    tick();
    @(negedge clk);
    check("rlu_f2", 32'(ctrl_of(1)), 32'(C_FRZ));
    tick();
    @(negedge clk);
    check("rlu_rel", 32'(ctrl_of(1)), 32'(C_RLLU));
    tick();

    // Branch with a simultaneous load-use: branch wins, no stall.
    do_reset();
    set_lu(4'h3, 4'h3, 1, 4'h0, 0, 1);
    branch_E = 1;
    @(negedge clk);
    check("br_lu", 32'(ctrl_of(1)), 32'(C_BR));
    tick();
    clear_in();
    @(negedge clk);
    check("br_cnt", 32'(cnt[1]), 32'h0);
    tick();

    // Branch held through a freeze, MEM_LAT=4 (inst 2).
    do_reset();
    memreq_M = 1;
    branch_E = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("brf_f%0d", c), 32'(ctrl_of(2)), 32'(C_FRZ));
      tick();
    end
    @(negedge clk);
    check("brf_rel", 32'(ctrl_of(2)), 32'(C_BR));
    tick();
    clear_in();
    @(negedge clk);
    check("brf_run", 32'(ctrl_of(2)), 32'(C_RUN));
    check("brf_cnt", 32'(cnt[2]), 32'h3);
    tick();

    // Reset at the third freeze cycle, MEM_LAT=8 (inst 3).
    do_reset();
    memreq_M = 1;
    tick();
    tick();
    @(negedge clk);
    check("rmw_f3", 32'(ctrl_of(3)), 32'(C_FRZ));
    check("rmw_busy", 32'(busy[3]), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("rmw_off", 32'(ctrl_of(3)), 32'(C_ZERO));
    check("rmw_off_busy", 32'(busy[3]), 32'h0);
    check("rmw_off_cnt", 32'(cnt[3]), 32'h0);
    memreq_M = 0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rmw_run", 32'(ctrl_of(3)), 32'(C_RUN));
    check("rmw_run_busy", 32'(busy[3]), 32'h0);
    check("rmw_run_cnt", 32'(cnt[3]), 32'h0);
    tick();

    // Stall-counter saturation under a held load-use.
    do_reset();
    set_lu(4'h2, 4'h2, 1, 4'h0, 0, 1);
    repeat (65534) @(posedge clk);
    @(negedge clk);
    check("sat_fffe", 32'(cnt[1]), 32'hFFFE);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("sat_ffff", 32'(cnt[1]), 32'hFFFF);
    clear_in();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
